// File: rtl/fp_pkg.sv
// fp_pkg: shared widths, packed types and operand unpacking for the FP add/sub front end.
// Latency: none (types and a combinational helper only).
// Backpressure: none.
//
// Build option FP_ALIGN_FTZ_EN: when defined, operands with a zero exponent field
// are flushed to exact zero; otherwise they are kept as subnormals with effective
// exponent 1 and hidden bit 0.
package fp_pkg;

    localparam int unsigned FP_EXP_W        = 5;
    localparam int unsigned FP_MANT_W       = 11;  // includes the hidden bit
    localparam int unsigned FP_DATA_W       = FP_EXP_W + FP_MANT_W;
    localparam int unsigned MAX_ALIGN_SHIFT = FP_MANT_W + 3;

    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;   // effective exponent
        logic [FP_MANT_W-1:0] mant;  // hidden bit at MSB
    } unpacked_operand_t;

    typedef struct packed {
        logic                 sign;        // sign of the larger operand
        logic [FP_EXP_W-1:0]  exp;         // exponent of the larger operand
        logic [FP_MANT_W-1:0] big_mant;
        logic [FP_MANT_W-1:0] small_mant;
        logic [FP_EXP_W-1:0]  shift;       // exponent difference, unsigned
        logic                 eff_sub;
    } s1_reg_t;

    // Splits a packed operand into sign / effective exponent / mantissa.
    // invert_sign folds the subtract request into operand B's sign.
    function automatic unpacked_operand_t unpack_operand(
        input logic [FP_DATA_W-1:0] op,
        input logic                 invert_sign
    );
        unpacked_operand_t u;
        u.sign = op[FP_DATA_W-1] ^ invert_sign;
        u.exp  = op[FP_DATA_W-2 -: FP_EXP_W];
        u.mant = {(u.exp != '0), op[FP_MANT_W-2:0]};
`ifdef FP_ALIGN_FTZ_EN
        if (u.exp == '0) begin
            u.mant = '0;
        end
`else
        // Subnormals sit on the same binade as exponent 1.
        if (u.exp == '0) begin
            u.exp = FP_EXP_W'(1);
        end
`endif
        return u;
    endfunction

endpackage

// File: rtl/align_shifter.sv
// align_shifter: right shifter that turns a mantissa into {mant, G, R, S} with sticky collection.
// Latency: combinational.
// Backpressure: none (pure datapath).
//
// Ports:
//   mant_i  [WIDTH-1:0]    mantissa to align
//   shamt_i [SHIFT_W-1:0]  requested right shift, saturated at MAX_SHIFT
//   ext_o   [WIDTH+2:0]    {shifted mantissa, guard, round, sticky}
module align_shifter #(
    parameter int unsigned WIDTH     = 11,
    parameter int unsigned MAX_SHIFT = 14,
    parameter int unsigned SHIFT_W   = 5
)(
    input  logic [WIDTH-1:0]   mant_i,
    input  logic [SHIFT_W-1:0] shamt_i,
    output logic [WIDTH+2:0]   ext_o
);

    // Mantissa, guard and round occupy the top WIDTH+2 bits; everything that
    // falls into the lower MAX_SHIFT bits is collapsed into sticky.
    localparam int unsigned TOT_W = WIDTH + 2 + MAX_SHIFT;

    logic [31:0]      shamt_sat;
    logic [TOT_W-1:0] shifted;

    always_comb begin
        shamt_sat = 32'(shamt_i);
        if (shamt_sat > MAX_SHIFT) begin
            shamt_sat = MAX_SHIFT;
        end
        shifted = {mant_i, {(2 + MAX_SHIFT){1'b0}}} >> shamt_sat;
        ext_o   = {shifted[TOT_W-1 -: WIDTH+2], |shifted[MAX_SHIFT-1:0]};
    end

endmodule

// File: rtl/fp_align_add.sv
// fp_align_add: FP add/sub front end - unpack, magnitude swap, align with G/R/S, mantissa add/sub.
// Latency: 2 cycles from accepted input to valid_o, one result per cycle.
// Backpressure: valid/ready; a stalled output holds and stage 1 keeps one more op, then ready_o drops.
//
// Ports:
//   clk_i, rst_ni (async active-low), flush_i (sync, highest priority)
//   valid_i / ready_o, operand_a_i, operand_b_i, sub_i (1 = A-B)
//   valid_o / ready_i, sign_o, exp_o, mant_carry_bit_o, mant_o,
//   mant_guard_bit_o, mant_round_bit_o, mant_sticky_bit_o, zero_o
//
// Build option FP_ALIGN_FTZ_EN (handled in fp_pkg::unpack_operand): flush
// zero-exponent operands to exact zero instead of treating them as subnormals.
// The packed stage types are sized in fp_pkg, so width overrides must match it.
module fp_align_add
    import fp_pkg::*;
#(
    parameter  int unsigned EXPONENT_WIDTH = FP_EXP_W,
    parameter  int unsigned MANTISSA_WIDTH = FP_MANT_W,
    localparam int unsigned DATA_WIDTH     = EXPONENT_WIDTH + MANTISSA_WIDTH
)(
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      flush_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic [DATA_WIDTH-1:0]     operand_a_i,
    input  logic [DATA_WIDTH-1:0]     operand_b_i,
    input  logic                      sub_i,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic                      sign_o,
    output logic [EXPONENT_WIDTH-1:0] exp_o,
    output logic                      mant_carry_bit_o,
    output logic [MANTISSA_WIDTH-1:0] mant_o,
    output logic                      mant_guard_bit_o,
    output logic                      mant_round_bit_o,
    output logic                      mant_sticky_bit_o,
    output logic                      zero_o
);

    localparam int unsigned EXT_W = MANTISSA_WIDTH + 3;  // {mant, G, R, S}

    // ---------------------------------------------------------------------
    // Handshake
    // ---------------------------------------------------------------------
    logic s1_valid;
    logic s2_valid;
    logic init_done;
    logic en1;
    logic en2;
    logic accept;

    assign en2     = !s2_valid || ready_i;
    assign en1     = !s1_valid || en2;
    // init_done keeps ready_o low during reset and for the first edge after it.
    assign ready_o = en1 && init_done && !flush_i;
    assign accept  = valid_i && ready_o;
    assign valid_o = s2_valid;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            init_done <= 1'b0;
        end else begin
            init_done <= 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Stage 1: unpack, order by magnitude, effective operation
    // ---------------------------------------------------------------------
    unpacked_operand_t op_a;
    unpacked_operand_t op_b;
    logic              a_is_big;
    s1_reg_t           s1_d;
    s1_reg_t           s1_q;

    always_comb begin
        op_a = unpack_operand(operand_a_i, 1'b0);
        op_b = unpack_operand(operand_b_i, sub_i);
        // Effective exponent and mantissa order the same way as the raw
        // {exp, fraction} field; a tie keeps A as the big operand.
        a_is_big     = {op_a.exp, op_a.mant} >= {op_b.exp, op_b.mant};
        s1_d         = '0;
        s1_d.eff_sub = op_a.sign ^ op_b.sign;
        if (a_is_big) begin
            s1_d.sign       = op_a.sign;
            s1_d.exp        = op_a.exp;
            s1_d.big_mant   = op_a.mant;
            s1_d.small_mant = op_b.mant;
            s1_d.shift      = op_a.exp - op_b.exp;
        end else begin
            s1_d.sign       = op_b.sign;
            s1_d.exp        = op_b.exp;
            s1_d.big_mant   = op_b.mant;
            s1_d.small_mant = op_a.mant;
            s1_d.shift      = op_b.exp - op_a.exp;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (flush_i) begin
            s1_valid <= 1'b0;
        end else if (en1) begin
            s1_valid <= accept;
            if (accept) begin
                s1_q <= s1_d;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stage 2: align the small operand, add or subtract
    // ---------------------------------------------------------------------
    logic [EXT_W-1:0] small_ext;
    logic [EXT_W-1:0] big_ext;
    logic [EXT_W:0]   res;
    logic             res_zero;

    align_shifter #(
        .WIDTH     (MANTISSA_WIDTH),
        .MAX_SHIFT (MAX_ALIGN_SHIFT),
        .SHIFT_W   (EXPONENT_WIDTH)
    ) u_align_shifter (
        .mant_i  (s1_q.small_mant),
        .shamt_i (s1_q.shift),
        .ext_o   (small_ext)
    );

    assign big_ext = {s1_q.big_mant, 3'b000};

    always_comb begin
        // big >= small by construction, so the difference never borrows.
        if (s1_q.eff_sub) begin
            res = {1'b0, big_ext - small_ext};
        end else begin
            res = {1'b0, big_ext} + {1'b0, small_ext};
        end
        res_zero = (res == '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_valid          <= 1'b0;
            sign_o            <= 1'b0;
            exp_o             <= '0;
            mant_carry_bit_o  <= 1'b0;
            mant_o            <= '0;
            mant_guard_bit_o  <= 1'b0;
            mant_round_bit_o  <= 1'b0;
            mant_sticky_bit_o <= 1'b0;
            zero_o            <= 1'b0;
        end else if (flush_i) begin
            s2_valid <= 1'b0;
        end else if (en2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                // Exact cancellation reports +0.
                sign_o            <= s1_q.sign && !res_zero;
                exp_o             <= s1_q.exp;
                mant_carry_bit_o  <= res[EXT_W];
                mant_o            <= res[EXT_W-1:3];
                mant_guard_bit_o  <= res[2];
                mant_round_bit_o  <= res[1];
                mant_sticky_bit_o <= res[0];
                zero_o            <= res_zero;
            end
        end
    end

endmodule

// File: tb/tb_fp_align_add.sv
// tb_fp_align_add: directed vectors, stall/flush/reset sequences and randomized
// traffic against an integer-arithmetic reference model with a result queue.
module tb_fp_align_add;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        valid_i;
    logic        ready_o;
    logic [15:0] operand_a_i;
    logic [15:0] operand_b_i;
    logic        sub_i;
    logic        valid_o;
    logic        ready_i;
    logic        sign_o;
    logic [4:0]  exp_o;
    logic        mant_carry_bit_o;
    logic [10:0] mant_o;
    logic        mant_guard_bit_o;
    logic        mant_round_bit_o;
    logic        mant_sticky_bit_o;
    logic        zero_o;

    fp_align_add dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .flush_i           (flush_i),
        .valid_i           (valid_i),
        .ready_o           (ready_o),
        .operand_a_i       (operand_a_i),
        .operand_b_i       (operand_b_i),
        .sub_i             (sub_i),
        .valid_o           (valid_o),
        .ready_i           (ready_i),
        .sign_o            (sign_o),
        .exp_o             (exp_o),
        .mant_carry_bit_o  (mant_carry_bit_o),
        .mant_o            (mant_o),
        .mant_guard_bit_o  (mant_guard_bit_o),
        .mant_round_bit_o  (mant_round_bit_o),
        .mant_sticky_bit_o (mant_sticky_bit_o),
        .zero_o            (zero_o)
    );

    always #5 clk_i = ~clk_i;

    // {zero, sign, exp[4:0], carry, mant[10:0], G, R, S}
    logic [21:0] dut_res;
    assign dut_res = {zero_o, sign_o, exp_o, mant_carry_bit_o, mant_o,
                      mant_guard_bit_o, mant_round_bit_o, mant_sticky_bit_o};

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [21:0] pk(input logic z, input logic s, input logic [4:0] e,
                                       input logic c, input logic [10:0] m, input logic [2:0] grs);
        return {z, s, e, c, m, grs};
    endfunction

    // Reference model: real-valued rules with integer arithmetic.
    function automatic logic [21:0] ref_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic sub);
        int   ea, eb, ma, mb, be, bm, se, sm, d, kept, lost, ext, res;
        logic sa, sb, bs, eff_sub, zero;
        sa = a[15];
        sb = b[15] ^ sub;
        eff_sub = sa ^ sb;
        ea = int'(a[14:10]); ma = int'(a[9:0]);
        eb = int'(b[14:10]); mb = int'(b[9:0]);
        if (ea != 0) ma = ma + 1024;
`ifdef FP_ALIGN_FTZ_EN
        else ma = 0;
`else
        else ea = 1;
`endif
        if (eb != 0) mb = mb + 1024;
`ifdef FP_ALIGN_FTZ_EN
        else mb = 0;
`else
        else eb = 1;
`endif
        if (a[14:0] >= b[14:0]) begin
            bs = sa; be = ea; bm = ma; se = eb; sm = mb;
        end else begin
            bs = sb; be = eb; bm = mb; se = ea; sm = ma;
        end
        d = be - se;
        if (d > 14) d = 14;
        kept = (sm * 4) >> d;                          // mantissa, G, R
        lost = (((sm * 4) % (1 << d)) != 0) ? 1 : 0;   // anything below R
        ext  = kept * 2 + lost;
        res  = eff_sub ? (bm * 8 - ext) : (bm * 8 + ext);
        zero = (res == 0);
        return {zero, zero ? 1'b0 : bs, be[4:0], res[14:0]};
    endfunction

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [21:0] req;
        string       name;
    } vec_t;

    vec_t vecs[13];

    logic [21:0] sb_q[$];

    task automatic gen_ops(output logic [15:0] a, output logic [15:0] b, output logic s);
        a = 16'($urandom);
        s = 1'($urandom);
        case ($urandom_range(0, 3))
            0: b = 16'($urandom);
            1: b = {1'($urandom), a[14:0]};
            2: begin
                b = 16'($urandom);
                b[14:10] = a[14:10] + 5'($urandom_range(0, 3));
            end
            default: begin
                a[14:10] = 5'($urandom_range(0, 2));
                b = 16'($urandom);
                b[14:10] = 5'($urandom_range(0, 2));
            end
        endcase
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] ra, rb;
        logic        rs;
        int          drain;

        vecs[0]  = '{16'h3C00, 16'h3C00, 1'b0, pk(0, 0, 15, 1, 11'h000, 3'b000), "one_plus_one"};
        vecs[1]  = '{16'h4200, 16'h3C00, 1'b1, pk(0, 0, 16, 0, 11'h400, 3'b000), "three_minus_one"};
        vecs[2]  = '{16'h3C00, 16'h0401, 1'b0, pk(0, 0, 15, 0, 11'h400, 3'b001), "sat_shift_d14"};
        vecs[3]  = '{16'h3C00, 16'h3C00, 1'b1, pk(1, 0, 15, 0, 11'h000, 3'b000), "cancel_sub"};
        vecs[4]  = '{16'hBC00, 16'h3C00, 1'b0, pk(1, 0, 15, 0, 11'h000, 3'b000), "cancel_neg_add"};
        vecs[5]  = '{16'h3C00, 16'h3C01, 1'b0, pk(0, 0, 15, 1, 11'h001, 3'b000), "swap_b_bigger"};
        vecs[6]  = '{16'h3C00, 16'h3403, 1'b0, pk(0, 0, 15, 0, 11'h500, 3'b110), "guard_round_d2"};
        vecs[7]  = '{16'h3C00, 16'h3401, 1'b1, pk(0, 0, 15, 0, 11'h2FF, 3'b110), "sub_borrow_d2"};
        vecs[8]  = '{16'h3C00, 16'h4000, 1'b1, pk(0, 1, 16, 0, 11'h200, 3'b000), "neg_result"};
        vecs[9]  = '{16'h3C00, 16'h0C01, 1'b0, pk(0, 0, 15, 0, 11'h400, 3'b011), "d12_round_sticky"};
`ifdef FP_ALIGN_FTZ_EN
        vecs[10] = '{16'h0000, 16'h8000, 1'b0, pk(1, 0, 0, 0, 11'h000, 3'b000), "zero_plus_negzero"};
        vecs[11] = '{16'h0200, 16'h0200, 1'b0, pk(1, 0, 0, 0, 11'h000, 3'b000), "subnormal_sum"};
        vecs[12] = '{16'h7800, 16'h0001, 1'b0, pk(0, 0, 30, 0, 11'h400, 3'b000), "huge_d_clamp"};
`else
        vecs[10] = '{16'h0000, 16'h8000, 1'b0, pk(1, 0, 1, 0, 11'h000, 3'b000), "zero_plus_negzero"};
        vecs[11] = '{16'h0200, 16'h0200, 1'b0, pk(0, 0, 1, 0, 11'h400, 3'b000), "subnormal_sum"};
        vecs[12] = '{16'h7800, 16'h0001, 1'b0, pk(0, 0, 30, 0, 11'h400, 3'b001), "huge_d_clamp"};
`endif

        // ---------------- reset state ----------------
        rst_ni = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        operand_a_i = '0; operand_b_i = '0; sub_i = 1'b0;
        #1;
        check("reset_valid_o", 32'(valid_o), 0);
        check("reset_ready_o", 32'(ready_o), 0);
        check("reset_data", 32'(dut_res), 0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check("ready_before_first_edge", 32'(ready_o), 0);
        @(negedge clk_i);
        check("ready_after_reset", 32'(ready_o), 1);

        // ---------------- directed table ----------------
        for (int i = 0; i < 13; i++) begin
            operand_a_i = vecs[i].a; operand_b_i = vecs[i].b; sub_i = vecs[i].sub;
            valid_i = 1'b1;
            @(negedge clk_i);
            valid_i = 1'b0;
            check("latency_not_early", 32'(valid_o), 0);
            @(negedge clk_i);
            check("latency_valid", 32'(valid_o), 1);
            check(vecs[i].name, 32'(dut_res), 32'(vecs[i].req));
            @(negedge clk_i);
        end

        // ---------------- backpressure ----------------
        ready_i = 1'b0;
        operand_a_i = vecs[5].a; operand_b_i = vecs[5].b; sub_i = vecs[5].sub; valid_i = 1'b1;
        #1 check("bp_ready_first", 32'(ready_o), 1);
        @(negedge clk_i);
        check("bp_ready_second", 32'(ready_o), 1);
        operand_a_i = vecs[6].a; operand_b_i = vecs[6].b; sub_i = vecs[6].sub;
        @(negedge clk_i);
        check("bp_ready_drops", 32'(ready_o), 0);
        check("bp_valid_held", 32'(valid_o), 1);
        check("bp_out_op0", 32'(dut_res), 32'(vecs[5].req));
        operand_a_i = vecs[7].a; operand_b_i = vecs[7].b; sub_i = vecs[7].sub;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_i);
            check("bp_stall_ready", 32'(ready_o), 0);
            check("bp_stall_valid", 32'(valid_o), 1);
            check("bp_stall_stable", 32'(dut_res), 32'(vecs[5].req));
        end
        ready_i = 1'b1;
        #1 check("bp_release_ready", 32'(ready_o), 1);
        @(negedge clk_i);
        valid_i = 1'b0;
        check("bp_drain_valid1", 32'(valid_o), 1);
        check("bp_drain_op1", 32'(dut_res), 32'(vecs[6].req));
        @(negedge clk_i);
        check("bp_drain_valid2", 32'(valid_o), 1);
        check("bp_drain_op2", 32'(dut_res), 32'(vecs[7].req));
        @(negedge clk_i);
        check("bp_drain_empty", 32'(valid_o), 0);

        // ---------------- flush with two ops in flight ----------------
        operand_a_i = vecs[1].a; operand_b_i = vecs[1].b; sub_i = vecs[1].sub; valid_i = 1'b1;
        @(negedge clk_i);
        operand_a_i = vecs[2].a; operand_b_i = vecs[2].b; sub_i = vecs[2].sub;
        @(negedge clk_i);
        check("flush_pre_valid", 32'(valid_o), 1);
        flush_i = 1'b1;
        operand_a_i = vecs[8].a; operand_b_i = vecs[8].b; sub_i = vecs[8].sub;
        #1 check("flush_blocks_ready", 32'(ready_o), 0);
        @(negedge clk_i);
        flush_i = 1'b0; valid_i = 1'b0;
        check("flush_valid_cleared", 32'(valid_o), 0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_i);
            check("flush_nothing_emitted", 32'(valid_o), 0);
        end

        // ---------------- reset mid-stream ----------------
        operand_a_i = vecs[0].a; operand_b_i = vecs[0].b; sub_i = vecs[0].sub; valid_i = 1'b1;
        @(negedge clk_i);
        operand_a_i = vecs[6].a; operand_b_i = vecs[6].b; sub_i = vecs[6].sub;
        @(negedge clk_i);
        valid_i = 1'b0; ready_i = 1'b0;
        check("rst_pre_valid", 32'(valid_o), 1);
        #2 rst_ni = 1'b0;
        #1;
        check("rst_mid_valid_o", 32'(valid_o), 0);
        check("rst_mid_ready_o", 32'(ready_o), 0);
        check("rst_mid_data", 32'(dut_res), 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("rst_after_ready", 32'(ready_o), 1);
        check("rst_after_valid", 32'(valid_o), 0);

        // ---------------- randomized traffic ----------------
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk_i);
            ready_i = ($urandom_range(0, 3) != 0);
            valid_i = ($urandom_range(0, 3) != 0);
            gen_ops(ra, rb, rs);
            operand_a_i = ra; operand_b_i = rb; sub_i = rs;
            #1;
            if (valid_o && ready_i) begin
                if (sb_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL rand_unexpected_output: got 0x%0h, expected no output", dut_res);
                end else begin
                    check("rand_result", 32'(dut_res), 32'(sb_q.pop_front()));
                end
            end
            if (valid_i && ready_o) sb_q.push_back(ref_model(ra, rb, rs));
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        drain = 0;
        while (sb_q.size() != 0 && drain < 20) begin
            @(negedge clk_i);
            #1;
            if (valid_o) check("rand_drain_result", 32'(dut_res), 32'(sb_q.pop_front()));
            drain++;
        end
        check("rand_all_drained", 32'(sb_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
